// File: rtl/logic_unit_pkg.sv
// Shared op encodings, statistics width and the per-bit op evaluation for the
// pipelined logic unit.
package logic_unit_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  localparam int unsigned STAT_W = 16;

  // Evaluated one bit at a time so the unit can use any WIDTH without padding.
  function automatic logic logic_eval(input logic [1:0] op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One valid/data register of the logic unit pipeline. It loads whenever it is
// empty or its contents are moving downstream in the same cycle.
module logic_pipe_stage #(
  parameter int unsigned DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          v_i,
  input  logic [DW-1:0] d_i,
  input  logic          adv_i,
  output logic          v_o,
  output logic [DW-1:0] d_o,
  output logic          adv_o
);

  logic          v_q, v_d;
  logic [DW-1:0] d_q, d_d;

  assign adv_o = ~v_q | adv_i;
  assign v_o   = v_q;
  assign d_o   = d_q;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (adv_o) begin
      v_d = v_i;
      if (v_i) d_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit AND/OR/XOR/NAND unit with valid/ready flow control.
// Define LOGIC_STATS_EN to add the saturating op_count transfer counter port.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero
`ifdef LOGIC_STATS_EN
  ,
  output logic [STAT_W-1:0] op_count
`endif
);

  localparam int unsigned DW = WIDTH + 1;

  logic [WIDTH-1:0] res;
  logic             vin  [STAGES];
  logic [DW-1:0]    din  [STAGES];
  logic             vq   [STAGES];
  logic [DW-1:0]    dq   [STAGES];
  logic             rdy  [STAGES+1];

  always_comb begin
    res = '0;
    for (int unsigned i = 0; i < WIDTH; i++) res[i] = logic_eval(op, a[i], b[i]);
  end

  // The zero flag travels with the data so it stays aligned through stalls.
  assign rdy[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vin[k] = in_valid;
      assign din[k] = {~|res, res};
    end else begin : g_body
      assign vin[k] = vq[k-1];
      assign din[k] = dq[k-1];
    end

    logic_pipe_stage #(.DW(DW)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .v_i   (vin[k]),
      .d_i   (din[k]),
      .adv_i (rdy[k+1]),
      .v_o   (vq[k]),
      .d_o   (dq[k]),
      .adv_o (rdy[k])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = vq[STAGES-1];
  assign out       = dq[STAGES-1][WIDTH-1:0];
  assign out_zero  = dq[STAGES-1][WIDTH];

`ifdef LOGIC_STATS_EN
  logic [STAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign op_count = cnt_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: three configurations share one random stream and
// are each tracked by a queue-based reference model.
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [1:0]  op;
  logic [31:0] a, b;

  logic        rdy8, ov8, oz8;
  logic [7:0]  o8;
  logic        rdy32, ov32, oz32;
  logic [31:0] o32;
  logic        rdy1, ov1, oz1;
  logic [0:0]  o1;
`ifdef LOGIC_STATS_EN
  logic [15:0] cnt8, cnt32, cnt1;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] q8[$], q32[$], q1[$];
  logic [2:0]  held;
  logic [31:0] hv[3];
  int unsigned xfer8, xfer32, xfer1;
  logic [7:0]  exp1[4];

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .STAGES(2)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8), .op(op),
    .a(a[7:0]), .b(b[7:0]), .out_valid(ov8), .out_ready(out_ready), .out(o8),
    .out_zero(oz8)
`ifdef LOGIC_STATS_EN
    , .op_count(cnt8)
`endif
  );

  logic_unit_pipe #(.WIDTH(32), .STAGES(4)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32), .op(op),
    .a(a), .b(b), .out_valid(ov32), .out_ready(out_ready), .out(o32),
    .out_zero(oz32)
`ifdef LOGIC_STATS_EN
    , .op_count(cnt32)
`endif
  );

  logic_unit_pipe #(.WIDTH(1), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .op(op),
    .a(a[0:0]), .b(b[0:0]), .out_valid(ov1), .out_ready(out_ready), .out(o1),
    .out_zero(oz1)
`ifdef LOGIC_STATS_EN
    , .op_count(cnt1)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_eval(input logic [1:0] o, input logic [31:0] x,
                                           input logic [31:0] y, input int w);
    logic [31:0] r;
    case (o)
      2'd0:    r = x & y;
      2'd1:    r = x | y;
      2'd2:    r = x ^ y;
      default: r = ~(x & y);
    endcase
    if (w < 32) r = r & ((32'd1 << w) - 32'd1);
    return r;
  endfunction

  // Handshakes are evaluated mid-cycle, when inputs and outputs are both stable.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) begin
      q8.delete(); q32.delete(); q1.delete();
      held = '0;
      xfer8 = 0; xfer32 = 0; xfer1 = 0;
    end else begin
      if (held[0]) begin check_eq("hold8_vld", 32'(ov8), 1); check_eq("hold8_out", 32'(o8), hv[0]); end
      if (held[1]) begin check_eq("hold32_vld", 32'(ov32), 1); check_eq("hold32_out", o32, hv[1]); end
      if (held[2]) begin check_eq("hold1_vld", 32'(ov1), 1); check_eq("hold1_out", 32'(o1), hv[2]); end
      held = {ov1 && !out_ready, ov32 && !out_ready, ov8 && !out_ready};
      hv[0] = 32'(o8); hv[1] = o32; hv[2] = 32'(o1);

      if (ov8 && out_ready) begin
        check_eq("sb8_avail", 32'(q8.size() != 0), 1);
        if (q8.size() != 0) begin
          e = q8.pop_front(); xfer8++;
          check_eq("sb8_out", 32'(o8), e); check_eq("sb8_zero", 32'(oz8), 32'(e == 0));
        end
      end
      if (ov32 && out_ready) begin
        check_eq("sb32_avail", 32'(q32.size() != 0), 1);
        if (q32.size() != 0) begin
          e = q32.pop_front(); xfer32++;
          check_eq("sb32_out", o32, e); check_eq("sb32_zero", 32'(oz32), 32'(e == 0));
        end
      end
      if (ov1 && out_ready) begin
        check_eq("sb1_avail", 32'(q1.size() != 0), 1);
        if (q1.size() != 0) begin
          e = q1.pop_front(); xfer1++;
          check_eq("sb1_out", 32'(o1), e); check_eq("sb1_zero", 32'(oz1), 32'(e == 0));
        end
      end

      if (in_valid && rdy8)  q8.push_back(ref_eval(op, a, b, 8));
      if (in_valid && rdy32) q32.push_back(ref_eval(op, a, b, 32));
      if (in_valid && rdy1)  q1.push_back(ref_eval(op, a, b, 1));
    end
  end

  task automatic put(input logic v, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    in_valid = v; op = o; a = x; b = y;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int unsigned base;
    exp1[0] = 8'h30; exp1[1] = 8'hFC; exp1[2] = 8'hCC; exp1[3] = 8'hCF;
    rst_n = 1'b0; out_ready = 1'b0;
    put(0, 2'd0, '0, '0);
    repeat (3) tick();
    check_eq("rst_vld8", 32'(ov8), 0);
    check_eq("rst_out8", 32'(o8), 0);
    check_eq("rst_zero8", 32'(oz8), 0);
    check_eq("rst_vld32", 32'(ov32), 0);
`ifdef LOGIC_STATS_EN
    check_eq("rst_cnt8", 32'(cnt8), 0);
`endif
    rst_n = 1'b1;
    tick();
    check_eq("rst_in_ready", 32'(rdy8), 1);

    // All four ops back-to-back, result one edge after capture for STAGES=2.
    out_ready = 1'b1;
    put(1, 2'd0, 32'hF0, 32'h3C);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) check_eq("t1_lat", 32'(ov8), 0);
      else begin
        check_eq("t1_vld", 32'(ov8), 1);
        check_eq("t1_out", 32'(o8), 32'(exp1[i-1]));
        check_eq("t1_zero", 32'(oz8), 0);
      end
      if (i < 3) put(1, 2'(i + 1), 32'hF0, 32'h3C);
      else       put(0, 2'd0, '0, '0);
    end

    put(1, 2'd0, 32'hAA, 32'h55);
    tick();
    put(1, 2'd2, 32'hAA, 32'h55);
    tick();
    check_eq("t2_and_out", 32'(o8), 32'h00);
    check_eq("t2_and_zero", 32'(oz8), 1);
    put(0, 2'd0, '0, '0);
    tick();
    check_eq("t2_xor_out", 32'(o8), 32'hFF);
    check_eq("t2_xor_zero", 32'(oz8), 0);
    repeat (6) tick();

    // Backpressure: only STAGES beats fit, then in_ready must fall.
    out_ready = 1'b0;
    acc = 0;
    base = xfer8;
    for (int i = 0; i < 5; i++) begin
      put(1, 2'(i), 32'(i * 17 + 3), 32'hA5);
      if (rdy8) acc++;
      tick();
    end
    check_eq("t3_accepts", 32'(acc), 2);
    check_eq("t3_in_ready", 32'(rdy8), 0);
    check_eq("t3_out_vld", 32'(ov8), 1);
    put(0, 2'd0, '0, '0);
    out_ready = 1'b1;
    repeat (6) tick();
    check_eq("t3_delivered", xfer8 - base, 2);
    check_eq("t3_drained", 32'(q8.size()), 0);

    // Reset with beats in flight.
    out_ready = 1'b0;
    put(1, 2'd1, 32'h12, 32'h34);
    tick();
    put(1, 2'd2, 32'h56, 32'h78);
    tick();
    put(0, 2'd0, '0, '0);
    check_eq("t4_full", 32'(ov8), 1);
    rst_n = 1'b0;
    #1;
    check_eq("t4_vld8", 32'(ov8), 0);
    check_eq("t4_out8", 32'(o8), 0);
    check_eq("t4_vld32", 32'(ov32), 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t4_no_stale", 32'(ov8 | ov32 | ov1), 0);
    end
    check_eq("t4_in_ready", 32'(rdy8), 1);

    for (int i = 0; i < 12000; i++) begin
      put($urandom_range(0, 3) != 0, 2'($urandom), $urandom, $urandom);
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    put(0, 2'd0, '0, '0);
    out_ready = 1'b1;
    repeat (8) tick();
    check_eq("t5_drain8", 32'(q8.size()), 0);
    check_eq("t5_drain32", 32'(q32.size()), 0);
    check_eq("t5_drain1", 32'(q1.size()), 0);
    check_eq("t5_volume", 32'(xfer8 > 5000 && xfer32 > 5000 && xfer1 > 5000), 1);

`ifdef LOGIC_STATS_EN
    check_eq("t6_cnt8", 32'(cnt8), (xfer8 > 65535) ? 32'hFFFF : xfer8);
    check_eq("t6_cnt32", 32'(cnt32), (xfer32 > 65535) ? 32'hFFFF : xfer32);
    for (int i = 0; i < 70000; i++) begin
      put(1, 2'($urandom), $urandom, $urandom);
      tick();
    end
    put(0, 2'd0, '0, '0);
    repeat (6) tick();
    check_eq("t6_sat8", 32'(cnt8), 32'hFFFF);
    check_eq("t6_sat1", 32'(cnt1), 32'hFFFF);
    check_eq("t6_sat32", 32'(cnt32), 32'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
